// File: rtl/kyber_parse_sampler.sv
// kyber_parse_sampler
// Consumes 64-bit SHAKE-128 squeeze words, buffers them as bytes and runs
// the Kyber Parse rejection sampler on byte triples. Each triple yields two
// 12-bit candidates; candidates below Q are emitted in order with an index.
// One polynomial (N_COEF accepted coefficients) per start pulse.
//
// Optional build macro PARSE_STATS_EN adds the reject_cnt and words_used
// statistics outputs. Without it the block has no statistics logic.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start, no requests issued
// RUN   | pop one byte triple when at least 3 bytes are buffered
// EMIT1 | offer d1 downstream (skipped without a valid cycle if d1 >= Q)
// EMIT2 | offer d2 downstream (skipped without a valid cycle if d2 >= Q)
// DONE  | one-cycle done pulse, buffer flushed, then back to IDLE

module kyber_parse_sampler #(
  parameter int Q         = 3329,
  parameter int N_COEF    = 256,
  // Must be a power of two so the byte pointers wrap naturally.
  parameter int BUF_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        gimme,
  output logic [11:0] coef_out,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic [7:0]  coef_idx,
  output logic        busy,
  output logic        done
`ifdef PARSE_STATS_EN
  ,
  output logic [15:0] reject_cnt,
  output logic [7:0]  words_used
`endif
);

  localparam int PW = $clog2(BUF_BYTES);
  localparam int CW = $clog2(BUF_BYTES + 1);
  localparam logic [11:0] Q12 = 12'(Q);
  localparam logic [7:0] LAST_IDX = 8'(N_COEF - 1);
  // Request threshold leaves room for two more words after gimme drops.
  localparam logic [CW-1:0] REQ_MAX = CW'(BUF_BYTES - 24);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_EMIT1,
    S_EMIT2,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]    byte_mem [BUF_BYTES];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;
  logic [11:0]   d1, d2;
  logic          d1_ok, d2_ok;
  logic          push, pop, hs, last_hs, flush;
  logic          busy_n, gimme_n;
  logic [7:0]    b0, b1, b2;

  assign busy    = (state == S_RUN) || (state == S_EMIT1) || (state == S_EMIT2);
  assign done    = (state == S_DONE);
  assign d1_ok   = (d1 < Q12);
  assign d2_ok   = (d2 < Q12);

  // A word in the same cycle as start belongs to the abandoned polynomial.
  assign push    = in_valid && busy && !start;
  assign pop     = (state == S_RUN) && (count >= CW'(3)) && !start;
  assign flush   = start || (state == S_DONE);

  assign hs      = coef_valid && coef_ready;
  assign last_hs = hs && (coef_idx == LAST_IDX);

  assign b0      = byte_mem[rd_ptr];
  assign b1      = byte_mem[rd_ptr + PW'(1)];
  assign b2      = byte_mem[rd_ptr + PW'(2)];

  // Output mux: a candidate is only offered while its EMIT state is active.
  always_comb begin
    coef_out   = 12'd0;
    coef_valid = 1'b0;
    if (state == S_EMIT1) begin
      coef_out   = d1;
      coef_valid = d1_ok;
    end else if (state == S_EMIT2) begin
      coef_out   = d2;
      coef_valid = d2_ok;
    end
  end

  // Next-state logic; start overrides everything.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = S_IDLE;
      S_RUN:   if (count >= CW'(3)) state_n = S_EMIT1;
      S_EMIT1: begin
        if (!d1_ok)       state_n = S_EMIT2;
        else if (last_hs) state_n = S_DONE;
        else if (hs)      state_n = S_EMIT2;
      end
      S_EMIT2: begin
        if (!d2_ok)       state_n = S_RUN;
        else if (last_hs) state_n = S_DONE;
        else if (hs)      state_n = S_RUN;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (start) state_n = S_RUN;
  end

  // Byte occupancy after this cycle's append and triple pop.
  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else begin
      count_n = count + (push ? CW'(8) : CW'(0)) - (pop ? CW'(3) : CW'(0));
    end
  end

  // Request decision is taken on next-cycle values so gimme is registered.
  always_comb begin
    busy_n  = (state_n == S_RUN) || (state_n == S_EMIT1) || (state_n == S_EMIT2);
    gimme_n = busy_n && (count_n <= REQ_MAX);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Byte storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < 8; k++) begin
        byte_mem[wr_ptr + PW'(k)] <= in_data[8*k +: 8];
      end
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_n;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(8);
        if (pop)  rd_ptr <= rd_ptr + PW'(3);
      end
    end
  end

  // Candidate registers: d1 = b0 + 256*(b1 & 0xF), d2 = (b1 >> 4) + 16*b2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1 <= 12'd0;
      d2 <= 12'd0;
    end else if (pop) begin
      d1 <= {b1[3:0], b0};
      d2 <= {b2, b1[7:4]};
    end
  end

  // Coefficient index; held at the last value after completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 coef_idx <= 8'd0;
    else if (start)           coef_idx <= 8'd0;
    else if (hs && !last_hs)  coef_idx <= coef_idx + 8'd1;
  end

  // Registered read request towards the keccak output FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gimme <= 1'b0;
    else      gimme <= gimme_n;
  end

`ifdef PARSE_STATS_EN
  logic rejecting;
  assign rejecting = ((state == S_EMIT1) && !d1_ok) || ((state == S_EMIT2) && !d2_ok);

  // Rejected-candidate counter, saturating; only advances while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     reject_cnt <= 16'd0;
    else if (start)                               reject_cnt <= 16'd0;
    else if (rejecting && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
  end

  // Accepted-word counter, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             words_used <= 8'd0;
    else if (start)                       words_used <= 8'd0;
    else if (push && words_used != 8'hFF) words_used <= words_used + 8'd1;
  end
`endif

endmodule

// File: tb/tb_kyber_parse_sampler.sv
// Directed bench for kyber_parse_sampler with a 1-cycle-latency keccak FIFO
// model and a reference Parse model over the words actually delivered.
module tb_kyber_parse_sampler;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, coef_ready;
  logic [63:0] in_data;
  logic        gimme, coef_valid, busy, done;
  logic [11:0] coef_out;
  logic [7:0]  coef_idx;
`ifdef PARSE_STATS_EN
  logic [15:0] reject_cnt;
  logic [7:0]  words_used;
`endif

  kyber_parse_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .gimme      (gimme),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_idx   (coef_idx),
    .busy       (busy),
    .done       (done)
`ifdef PARSE_STATS_EN
    ,
    .reject_cnt (reject_cnt),
    .words_used (words_used)
`endif
  );

  always #5 clk = ~clk;

  logic [63:0] feed_q[$];
  logic [63:0] sent_q[$];
  int          got_c[$];
  int          got_i[$];
  int          exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  bit          pend = 0;
  bit          saw_valid = 0;
  bit          ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: record outputs, model keccak FIFO, advance to edge+1.
  task automatic cyc();
    if (coef_valid && coef_ready) begin
      got_c.push_back(int'(coef_out));
      got_i.push_back(int'(coef_idx));
    end
    if (coef_valid) saw_valid = 1;
    if (done) done_cnt++;
    if (dut.count > 32) ovf = 1;
    if (pend && feed_q.size() > 0) begin
      in_data  = feed_q.pop_front();
      in_valid = 1'b1;
      sent_q.push_back(in_data);
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
    pend = gimme;
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    logic rdy;
    rdy = coef_ready;
    in_valid = 1'b0;
    in_data  = '0;
    pend = 0;
    feed_q.delete(); sent_q.delete(); got_c.delete(); got_i.delete();
    done_cnt = 0; saw_valid = 0;
    coef_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    coef_ready = rdy;
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got_c.size() < n && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, 32'(got_c.size()), 32'(n));
  endtask

  task automatic feed_rand(input int n);
    for (int i = 0; i < n; i++) feed_q.push_back({$urandom, $urandom});
  endtask

  // Reference Parse over delivered bytes, then compare first n outputs.
  task automatic cmp_stream(input int n, input string tag);
    int bq[$];
    int i, v1, v2, m;
    bq.delete(); exp_q.delete();
    foreach (sent_q[w]) for (int k = 0; k < 8; k++) bq.push_back(int'((sent_q[w] >> (8*k)) & 64'hFF));
    i = 0;
    while (exp_q.size() < n && i + 2 < bq.size()) begin
      v1 = bq[i] + 256 * (bq[i+1] % 16);
      v2 = (bq[i+1] / 16) + 16 * bq[i+2];
      if (v1 < 3329) exp_q.push_back(v1);
      if (v2 < 3329 && exp_q.size() < n) exp_q.push_back(v2);
      i += 3;
    end
    m = (got_c.size() < n) ? got_c.size() : n;
    for (int j = 0; j < m; j++) begin
      chk($sformatf("%s_val%0d", tag, j), 32'(got_c[j]), 32'(exp_q[j]));
      chk($sformatf("%s_idx%0d", tag, j), 32'(got_i[j]), 32'(j));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] h_out;
    logic [7:0]  h_idx;
    int          k;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; coef_ready = 1'b1;
    #12;
    chk("rst_gimme", 32'(gimme), 0);
    chk("rst_coef_out", 32'(coef_out), 0);
    chk("rst_coef_valid", 32'(coef_valid), 0);
    chk("rst_coef_idx", 32'(coef_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
`ifdef PARSE_STATS_EN
    chk("rst_reject_cnt", 32'(reject_cnt), 0);
    chk("rst_words_used", 32'(words_used), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(); cyc();

    // Triple test: bytes 01 02 03 -> 513, 48
    do_start();
    chk("triple_busy", 32'(busy), 1);
    feed_q.push_back(64'h0807060504030201);
    feed_q.push_back(64'h100F0E0D0C0B0A09);
    wait_got(2, 50, "triple_got");
    chk("triple_c0", 32'(got_c[0]), 513);
    chk("triple_i0", 32'(got_i[0]), 0);
    chk("triple_c1", 32'(got_c[1]), 48);
    chk("triple_i1", 32'(got_i[1]), 1);

    // Boundary: 00 1D D0 -> 3328 accepted, 3329 rejected
    do_start();
    feed_q.push_back(64'h0000_0302_01D0_1D00);
    feed_q.push_back(64'h0);
    wait_got(3, 50, "bound_got");
    chk("bound_c0", 32'(got_c[0]), 3328);
    chk("bound_c1", 32'(got_c[1]), 513);
    chk("bound_i1", 32'(got_i[1]), 1);
    chk("bound_c2", 32'(got_c[2]), 48);
`ifdef PARSE_STATS_EN
    chk("bound_reject_cnt", 32'(reject_cnt), 1);
`endif

    // All-reject: 6 words of FF give 16 triples and 32 rejects
    do_start();
    for (int i = 0; i < 6; i++) feed_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 200; i++) cyc();
    chk("allrej_no_valid", 32'(saw_valid), 0);
    chk("allrej_busy", 32'(busy), 1);
    chk("allrej_gimme", 32'(gimme), 1);
    chk("allrej_words_sent", 32'(sent_q.size()), 6);
`ifdef PARSE_STATS_EN
    chk("allrej_reject_cnt", 32'(reject_cnt), 32);
    chk("allrej_words_used", 32'(words_used), 6);
`endif

    // Backpressure: hold ready low for 10 cycles mid-stream
    do_start();
    feed_rand(40);
    wait_got(5, 100, "bp_pre_got");
    coef_ready = 1'b0;
    k = 0;
    while (!coef_valid && k < 30) begin cyc(); k++; end
    chk("bp_valid_seen", 32'(coef_valid), 1);
    h_out = coef_out;
    h_idx = coef_idx;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("bp_hold_out%0d", i), 32'(coef_out), 32'(h_out));
      chk($sformatf("bp_hold_idx%0d", i), 32'(coef_idx), 32'(h_idx));
      chk($sformatf("bp_hold_valid%0d", i), 32'(coef_valid), 1);
    end
    coef_ready = 1'b1;
    wait_got(40, 300, "bp_got");
    cmp_stream(40, "bp");

    // Full run with random readiness
    do_start();
    feed_rand(200);
    k = 0;
    while (done_cnt == 0 && k < 5000) begin
      coef_ready = ($urandom_range(0, 3) != 0);
      cyc();
      k++;
    end
    coef_ready = 1'b1;
    chk("full_done_seen", 32'(done_cnt), 1);
    chk("full_count", 32'(got_c.size()), 256);
    if (got_i.size() > 0) chk("full_last_idx", 32'(got_i[got_i.size()-1]), 255);
    cmp_stream(256, "full");
    chk("full_after_gimme", 32'(gimme), 0);
    chk("full_after_busy", 32'(busy), 0);
    chk("full_after_done", 32'(done), 0);
    for (int i = 0; i < 20; i++) cyc();
    chk("full_done_once", 32'(done_cnt), 1);
    chk("full_idle_gimme", 32'(gimme), 0);

    // Restart mid-polynomial
    do_start();
    feed_rand(100);
    wait_got(30, 200, "rs_pre_got");
    do_start();
    feed_rand(50);
    wait_got(10, 100, "rs_got");
    cmp_stream(10, "rs");

    // Asynchronous reset mid-stream
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("ar_gimme", 32'(gimme), 0);
    chk("ar_coef_out", 32'(coef_out), 0);
    chk("ar_coef_valid", 32'(coef_valid), 0);
    chk("ar_coef_idx", 32'(coef_idx), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(done), 0);
`ifdef PARSE_STATS_EN
    chk("ar_reject_cnt", 32'(reject_cnt), 0);
    chk("ar_words_used", 32'(words_used), 0);
`endif
    feed_q.delete(); pend = 0;
    cyc(); cyc();
    rst = 1'b1;
    feed_rand(10);
    saw_valid = 0;
    for (int i = 0; i < 10; i++) cyc();
    chk("ar_idle_busy", 32'(busy), 0);
    chk("ar_idle_gimme", 32'(gimme), 0);
    chk("ar_idle_valid", 32'(saw_valid), 0);
    do_start();
    feed_rand(20);
    wait_got(3, 50, "ar_post_got");
    cmp_stream(3, "ar_post");

    chk("no_overflow", 32'(ovf), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/kyber_parse_sampler.md
Name: kyber_parse_sampler

Overview:
- Downstream consumer of the keccak squeeze output in SHAKE-128 mode.
- Pulls 64-bit words through the gimme/out_valid handshake and applies rejection sampling (Parse) on byte triples.
- Emits N_COEF uniform 12-bit coefficients < Q, in order, to the polynomial-memory writer.
- One matrix-A polynomial per start.

Parameters:
- Q, 3329, modulus; candidates >= Q are rejected.
- N_COEF, 256, accepted coefficients per polynomial.
- BUF_BYTES, 32, byte buffer depth (>= 3 words + 8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- start  in  1  one-cycle pulse; clears state and begins a polynomial.
- in_data  in  64  squeezed word (keccak out); byte k = in_data[8k+7:8k], byte 0 consumed first.
- in_valid  in  1  in_data valid this cycle (keccak out_valid).
- gimme  out  1  read request to keccak output FIFO (rd_en).
- coef_out  out  12  sampled coefficient.
- coef_valid  out  1  coef_out valid.
- coef_ready  in  1  downstream accepts when coef_valid & coef_ready.
- coef_idx  out  8  index (0..N_COEF-1) of the coefficient on coef_out.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse after the N_COEF-th coefficient is accepted.

Behaviour:
- Reset values: gimme=0, coef_out=0, coef_valid=0, coef_idx=0, busy=0, done=0; buffer count=0; FSM=IDLE.
- FSM: IDLE -> (start) RUN -> EMIT1 -> EMIT2 -> RUN ... -> DONE -> IDLE.
- start in any state: flush buffer, coef_idx=0, enter RUN next cycle; an in-flight word in the same cycle is dropped.
- Buffer: byte FIFO of BUF_BYTES.
  - Any cycle with in_valid=1 and busy=1 appends 8 bytes.
  - in_valid while not busy: word is dropped.
  - Append and triple-consume in the same cycle are both applied; count' = count + 8 - 3.
- gimme: registered; gimme=1 iff busy, FSM!=DONE and count <= BUF_BYTES-24.
  - Guarantees room for up to 2 words still in flight after deassertion.
  - Overflow is impossible by construction; the bench asserts it never occurs.
- RUN: if count >= 3, pop bytes b0,b1,b2 and compute:
  - d1 = b0 + 256*(b1 & 0xF)
  - d2 = (b1 >> 4) + 16*b2
  - Both are 12-bit and held in registers.
  - Go to EMIT1. If count < 3, stay in RUN.
- EMIT1: if d1 < Q, drive coef_out=d1 with coef_valid=1 and hold until handshake, then go to EMIT2. Otherwise go to EMIT2 immediately (zero emit cycles).
- EMIT2: same for d2, then return to RUN.
- coef_out and coef_idx stay stable while coef_valid & ~coef_ready; coef_idx increments on each handshake.
- Completion:
  - When the handshake occurs at coef_idx == N_COEF-1: go to DONE, pulse done one cycle, busy=0 and gimme=0 next cycle.
  - A pending d2 and any leftover bytes are discarded.
  - Words arriving afterwards are dropped.
- DONE -> IDLE after one cycle.
- Throughput: at most one coefficient per cycle. Minimum 3 cycles per triple with both accepted and coef_ready=1 (RUN, EMIT1, EMIT2).
- Comparison is unsigned 12-bit against Q; d = Q-1 is accepted, d = Q is rejected.

Optional Feature:
- Macro PARSE_STATS_EN.
- Defined:
  - Adds output reject_cnt[15:0]: number of candidates rejected since the last start.
  - Saturates at 0xFFFF, cleared by start and reset, frozen after done.
  - Adds output words_used[7:0]: words accepted from keccak since start.
- Undefined: neither port exists and no counter logic is synthesized; all other behaviour is identical.

Test Plan:
- Triple test:
  - Stimulus: reset, start; first word bytes 0x01,0x02,0x03,... with coef_ready=1.
  - Required: coef_out=513 (idx 0), then 48 (idx 1).
- Boundary:
  - Stimulus: triple 0x00,0x1D,0xD0.
  - Required: emits 3328 only. d2=3329 is rejected, next coefficient comes from the following triple, reject_cnt=1 with PARSE_STATS_EN.
- All-reject:
  - Stimulus: words of 0xFF bytes.
  - Required: no coef_valid, gimme keeps requesting, reject_cnt grows by 16 per 3 words, busy stays 1.
- Backpressure:
  - Stimulus: coef_ready held low for 10 cycles mid-stream.
  - Required: coef_out and coef_idx are stable, no buffer overflow, no lost coefficient; stream resumes in order.
- Full run:
  - Stimulus: random bytes until 256 accepts.
  - Required: coef_idx reaches 255, done pulses exactly once, output matches a reference Parse model, gimme=0 after done.
- Restart/reset:
  - Stimulus: start mid-polynomial, then rst=0 mid-stream.
  - Required: on start, idx restarts at 0 and the buffer is flushed. On rst=0, all outputs go to reset values immediately and the block idles until the next start.
